// File: rtl/icache_areq_tracker.sv
// icache_areq_tracker: round-robin arbiter and in-order ID FIFO between NR_CH fetch requesters
// and the single MMU fetch-translation port. Each MMU response is routed back to the channel
// that issued it; flushed requests are retired silently.
// Optional watchdog: define ICACHE_AREQ_TRACKER_TIMEOUT_EN to enable timeout_o.
module icache_areq_tracker #(
   parameter int unsigned NR_CH   = 2,
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned VLEN    = 39,
   parameter int unsigned PLEN    = 56,
   parameter int unsigned XLEN    = 64,
   parameter int unsigned TIMEOUT = 256
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       flush_i,
   input  logic [NR_CH-1:0]           ch_req_i,
   input  logic [NR_CH*VLEN-1:0]      ch_vaddr_i,
   output logic [NR_CH-1:0]           ch_gnt_o,
   output logic [NR_CH-1:0]           ch_rsp_valid_o,
   output logic [PLEN-1:0]            ch_rsp_paddr_o,
   output logic                       ch_rsp_ex_valid_o,
   output logic [XLEN-1:0]            ch_rsp_cause_o,
   output logic [XLEN-1:0]            ch_rsp_tval_o,
   output logic                       mmu_fetch_req_o,
   output logic [VLEN-1:0]            mmu_fetch_vaddr_o,
   input  logic                       mmu_fetch_valid_i,
   input  logic [PLEN-1:0]            mmu_fetch_paddr_i,
   input  logic                       mmu_ex_valid_i,
   input  logic [XLEN-1:0]            mmu_ex_cause_i,
   input  logic [XLEN-1:0]            mmu_ex_tval_i,
   output logic [$clog2(DEPTH+1)-1:0] outstanding_o,
   output logic                       full_o,
   output logic                       timeout_o
);

   localparam int unsigned ChW  = (NR_CH > 1) ? $clog2(NR_CH) : 1;
   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = $clog2(DEPTH + 1);

   // Arbitration
   logic [ChW-1:0] rr_q, rr_d;
   logic [ChW-1:0] cand;
   logic [ChW-1:0] gnt_idx;
   logic           gnt_found;
   logic           grant;

   // ID FIFO
   logic [DEPTH-1:0][ChW-1:0] id_q, id_d;
   logic [DEPTH-1:0]          kill_q, kill_d;
   logic [PtrW-1:0]           wptr_q, wptr_d;
   logic [PtrW-1:0]           rptr_q, rptr_d;
   logic [CntW-1:0]           cnt_q, cnt_d;
   logic                      fifo_pop;
   logic                      deliver;
   logic [ChW-1:0]            head_id;

   // Response registers
   logic [NR_CH-1:0] rsp_valid_q, rsp_valid_d;
   logic [PLEN-1:0]  paddr_q, paddr_d;
   logic             ex_valid_q, ex_valid_d;
   logic [XLEN-1:0]  cause_q, cause_d;
   logic [XLEN-1:0]  tval_q, tval_d;

   assign full_o        = (cnt_q == CntW'(DEPTH));
   assign outstanding_o = cnt_q;

   // Round-robin search starting at rr_q; first requesting channel wins
   always_comb begin
      cand      = '0;
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int unsigned i = 0; i < NR_CH; i++) begin
         cand = ChW'((32'(rr_q) + i) % NR_CH);
         if (!gnt_found && ch_req_i[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

   // Grant qualification, one-hot grant, MMU issue and pointer advance
   always_comb begin
      grant    = gnt_found & ~full_o & ~flush_i & ~rst_i;
      ch_gnt_o = '0;
      if (grant) begin
         ch_gnt_o[gnt_idx] = 1'b1;
      end
      mmu_fetch_req_o   = grant;
      mmu_fetch_vaddr_o = ch_vaddr_i[32'(gnt_idx) * VLEN +: VLEN];
      rr_d = rr_q;
      if (grant) begin
         rr_d = (32'(gnt_idx) == NR_CH - 1) ? '0 : gnt_idx + 1'b1;
      end
   end

   // FIFO push/pop; a flush marks every slot killed, including the one popped this cycle
   always_comb begin
      fifo_pop = mmu_fetch_valid_i & (cnt_q != '0);
      head_id  = id_q[rptr_q];
      deliver  = fifo_pop & ~kill_q[rptr_q] & ~flush_i;
      id_d     = id_q;
      kill_d   = kill_q;
      wptr_d   = wptr_q;
      rptr_d   = rptr_q;
      cnt_d    = cnt_q;
      if (flush_i) begin
         kill_d = '1;
      end
      if (grant) begin
         id_d[wptr_q]   = gnt_idx;
         kill_d[wptr_q] = 1'b0;
         wptr_d         = wptr_q + 1'b1;
      end
      if (fifo_pop) begin
         rptr_d = rptr_q + 1'b1;
      end
      if (grant && !fifo_pop) begin
         cnt_d = cnt_q + 1'b1;
      end else if (!grant && fifo_pop) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Response strobe is a single-cycle pulse; data fields hold between strobes
   always_comb begin
      rsp_valid_d = '0;
      ex_valid_d  = 1'b0;
      paddr_d     = paddr_q;
      cause_d     = cause_q;
      tval_d      = tval_q;
      if (deliver) begin
         rsp_valid_d[head_id] = 1'b1;
         ex_valid_d           = mmu_ex_valid_i;
         paddr_d              = mmu_fetch_paddr_i;
         cause_d              = mmu_ex_cause_i;
         tval_d               = mmu_ex_tval_i;
      end
   end

   // State registers, cleared asynchronously
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rr_q        <= '0;
         id_q        <= '0;
         kill_q      <= '0;
         wptr_q      <= '0;
         rptr_q      <= '0;
         cnt_q       <= '0;
         rsp_valid_q <= '0;
         paddr_q     <= '0;
         ex_valid_q  <= 1'b0;
         cause_q     <= '0;
         tval_q      <= '0;
      end else begin
         rr_q        <= rr_d;
         id_q        <= id_d;
         kill_q      <= kill_d;
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         cnt_q       <= cnt_d;
         rsp_valid_q <= rsp_valid_d;
         paddr_q     <= paddr_d;
         ex_valid_q  <= ex_valid_d;
         cause_q     <= cause_d;
         tval_q      <= tval_d;
      end
   end

   assign ch_rsp_valid_o    = rsp_valid_q;
   assign ch_rsp_paddr_o    = paddr_q;
   assign ch_rsp_ex_valid_o = ex_valid_q;
   assign ch_rsp_cause_o    = cause_q;
   assign ch_rsp_tval_o     = tval_q;

`ifdef ICACHE_AREQ_TRACKER_TIMEOUT_EN
   localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

   logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic            timeout_q, timeout_d;

   // Watchdog counts stalled cycles with work in flight; saturates at TIMEOUT
   always_comb begin
      tmo_cnt_d = tmo_cnt_q;
      if (fifo_pop || flush_i || (cnt_q == '0)) begin
         tmo_cnt_d = '0;
      end else if (tmo_cnt_q != TmoW'(TIMEOUT)) begin
         tmo_cnt_d = tmo_cnt_q + 1'b1;
      end
      timeout_d = flush_i ? 1'b0 : (timeout_q | (tmo_cnt_d == TmoW'(TIMEOUT)));
   end

   // Watchdog registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tmo_cnt_q <= '0;
         timeout_q <= 1'b0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout_o = timeout_q;
`else
   assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_icache_areq_tracker.sv
// Self-checking bench for icache_areq_tracker: directed scenarios then random traffic, all
// checked each cycle against a queue-based reference model of the tracker.
module tb_icache_areq_tracker;

   localparam int unsigned NR_CH   = 2;
   localparam int unsigned DEPTH   = 4;
   localparam int unsigned VLEN    = 39;
   localparam int unsigned PLEN    = 56;
   localparam int unsigned XLEN    = 64;
   localparam int unsigned TIMEOUT = 8;
   localparam int unsigned CntW    = $clog2(DEPTH + 1);
   localparam int unsigned VW      = NR_CH * VLEN;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                flush = 1'b0;
   logic [NR_CH-1:0]    req = '0;
   logic [VW-1:0]       vaddr = '0;
   logic [NR_CH-1:0]    gnt;
   logic [NR_CH-1:0]    rsp_v;
   logic [PLEN-1:0]     rsp_paddr;
   logic                rsp_exv;
   logic [XLEN-1:0]     rsp_cause;
   logic [XLEN-1:0]     rsp_tval;
   logic                mmu_req;
   logic [VLEN-1:0]     mmu_vaddr;
   logic                mv = 1'b0;
   logic [PLEN-1:0]     m_paddr = '0;
   logic                m_exv = 1'b0;
   logic [XLEN-1:0]     m_cause = '0;
   logic [XLEN-1:0]     m_tval = '0;
   logic [CntW-1:0]     outstanding;
   logic                full;
   logic                timeout;

   always #5 clk = ~clk;

   icache_areq_tracker #(
      .NR_CH(NR_CH), .DEPTH(DEPTH), .VLEN(VLEN), .PLEN(PLEN), .XLEN(XLEN), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .flush_i(flush),
      .ch_req_i(req),
      .ch_vaddr_i(vaddr),
      .ch_gnt_o(gnt),
      .ch_rsp_valid_o(rsp_v),
      .ch_rsp_paddr_o(rsp_paddr),
      .ch_rsp_ex_valid_o(rsp_exv),
      .ch_rsp_cause_o(rsp_cause),
      .ch_rsp_tval_o(rsp_tval),
      .mmu_fetch_req_o(mmu_req),
      .mmu_fetch_vaddr_o(mmu_vaddr),
      .mmu_fetch_valid_i(mv),
      .mmu_fetch_paddr_i(m_paddr),
      .mmu_ex_valid_i(m_exv),
      .mmu_ex_cause_i(m_cause),
      .mmu_ex_tval_i(m_tval),
      .outstanding_o(outstanding),
      .full_o(full),
      .timeout_o(timeout)
   );

   // Reference model: queue of in-flight requests (owner channel + killed flag)
   typedef struct {
      int ch;
      bit kill;
   } ent_t;

   ent_t             mq[$];
   int               m_rr;
   logic [NR_CH-1:0] e_rsp_v;
   logic [PLEN-1:0]  e_paddr;
   logic             e_exv;
   logic [XLEN-1:0]  e_cause;
   logic [XLEN-1:0]  e_tval;
   int               m_tc;
   bit               m_to;
   logic [NR_CH-1:0] last_gnt;

   int tests = 0;
   int fails = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      mq.delete();
      m_rr    = 0;
      e_rsp_v = '0;
      e_paddr = '0;
      e_exv   = 1'b0;
      e_cause = '0;
      e_tval  = '0;
      m_tc    = 0;
      m_to    = 1'b0;
   endtask

   // One clock: inputs already driven after a negedge; ends at the next negedge
   task automatic cycle();
      int               g;
      int               sz;
      int               c;
      bit               pop;
      bit               dlv;
      ent_t             e;
      ent_t             ne;
      logic [NR_CH-1:0] exp_gnt;
      #1;
      sz = mq.size();
      g  = -1;
      if (!flush && sz < DEPTH) begin
         for (int i = 0; i < NR_CH; i++) begin
            c = (m_rr + i) % NR_CH;
            if (g < 0 && req[c]) g = c;
         end
      end
      exp_gnt = '0;
      if (g >= 0) exp_gnt[g] = 1'b1;
      last_gnt = gnt;
      check("gnt", gnt, exp_gnt);
      check("mmu_req", mmu_req, g >= 0);
      if (g >= 0) check("mmu_vaddr", mmu_vaddr, vaddr[g*VLEN +: VLEN]);
      check("outstanding", outstanding, sz);
      check("full", full, sz == DEPTH);

      pop = mv && sz > 0;
      dlv = 1'b0;
      if (pop) begin
         e   = mq.pop_front();
         dlv = !e.kill && !flush;
      end
      if (flush) foreach (mq[i]) mq[i].kill = 1'b1;
      if (g >= 0) begin
         ne.ch   = g;
         ne.kill = 1'b0;
         mq.push_back(ne);
         m_rr = (g + 1) % NR_CH;
      end
      e_rsp_v = '0;
      e_exv   = 1'b0;
      if (dlv) begin
         e_rsp_v[e.ch] = 1'b1;
         e_exv         = m_exv;
         e_paddr       = m_paddr;
         e_cause       = m_cause;
         e_tval        = m_tval;
      end
`ifdef ICACHE_AREQ_TRACKER_TIMEOUT_EN
      if (pop || flush || sz == 0) m_tc = 0;
      else if (m_tc < TIMEOUT) m_tc++;
      if (flush) m_to = 1'b0;
      else if (m_tc == TIMEOUT) m_to = 1'b1;
`endif

      @(posedge clk);
      #1;
      check("rsp_valid", rsp_v, e_rsp_v);
      check("rsp_paddr", rsp_paddr, e_paddr);
      check("rsp_ex_valid", rsp_exv, e_exv);
      check("rsp_cause", rsp_cause, e_cause);
      check("rsp_tval", rsp_tval, e_tval);
      check("timeout", timeout, m_to);
      @(negedge clk);
   endtask

   task automatic step(input logic [NR_CH-1:0] r, input logic f, input logic v,
                       input logic [PLEN-1:0] pa, input logic ev,
                       input logic [XLEN-1:0] cs, input logic [XLEN-1:0] tv);
      req     = r;
      flush   = f;
      mv      = v;
      m_paddr = pa;
      m_exv   = ev;
      m_cause = cs;
      m_tval  = tv;
      cycle();
   endtask

   // Asynchronous reset asserted between edges; outputs must clear without a clock
   task automatic async_reset();
      #2;
      rst   = 1'b1;
      req   = '1;
      flush = 1'b0;
      mv    = 1'b0;
      #1;
      check("rst_outstanding", outstanding, 0);
      check("rst_full", full, 0);
      check("rst_gnt", gnt, 0);
      check("rst_mmu_req", mmu_req, 0);
      check("rst_rsp_valid", rsp_v, 0);
      check("rst_paddr", rsp_paddr, 0);
      check("rst_ex_valid", rsp_exv, 0);
      check("rst_cause", rsp_cause, 0);
      check("rst_tval", rsp_tval, 0);
      check("rst_timeout", timeout, 0);
      model_clear();
      @(negedge clk);
      rst = 1'b0;
      req = '0;
   endtask

   initial begin
      model_clear();
      @(negedge clk);
      async_reset();

      // Single channel, in-order
      vaddr              = '0;
      vaddr[VLEN-1:0]    = 39'h1000;
      step(2'b01, 0, 0, '0, 0, '0, '0);
      check("t1_gnt", last_gnt, 2'b01);
      step(2'b00, 0, 0, '0, 0, '0, '0);
      step(2'b00, 0, 0, '0, 0, '0, '0);
      step(2'b00, 0, 1, 56'h8000_1000, 0, '0, '0);
      check("t1_rsp", rsp_v, 2'b01);
      check("t1_paddr", rsp_paddr, 56'h8000_1000);

      // Round-robin to full, no grant while full even in a pop cycle
      async_reset();
      vaddr = VW'({$urandom(), $urandom(), $urandom()});
      step(2'b11, 0, 0, '0, 0, '0, '0);
      check("rr_gnt0", last_gnt, 2'b01);
      step(2'b11, 0, 0, '0, 0, '0, '0);
      check("rr_gnt1", last_gnt, 2'b10);
      step(2'b11, 0, 0, '0, 0, '0, '0);
      step(2'b11, 0, 0, '0, 0, '0, '0);
      check("rr_full", full, 1'b1);
      step(2'b11, 0, 1, 56'hA0, 0, '0, '0);
      check("rr_full_pop_gnt", last_gnt, 2'b00);
      check("rr_rsp0", rsp_v, 2'b01);
      step(2'b11, 0, 1, 56'hA1, 0, '0, '0);
      check("rr_rsp1", rsp_v, 2'b10);
      for (int i = 0; i < 3; i++) step(2'b00, 0, 1, 56'hB0 + 56'(i), 0, '0, '0);

      // Flush mid-flight
      for (int i = 0; i < 3; i++) step(2'b01, 0, 0, '0, 0, '0, '0);
      step(2'b01, 1, 1, 56'hC0, 0, '0, '0);
      check("fl_gnt", last_gnt, 2'b00);
      step(2'b01, 0, 0, '0, 0, '0, '0);
      check("fl_regnt", last_gnt, 2'b01);
      step(2'b00, 0, 1, 56'hC1, 0, '0, '0);
      step(2'b00, 0, 1, 56'hC2, 0, '0, '0);
      step(2'b00, 0, 1, 56'hC3, 0, '0, '0);
      check("fl_rsp", rsp_v, 2'b01);

      // Exception forwarding
      step(2'b10, 0, 0, '0, 0, '0, '0);
      step(2'b00, 0, 1, 56'hD0, 1, 64'd1, 64'hDEAD0);
      check("ex_rsp", rsp_v, 2'b10);
      check("ex_valid", rsp_exv, 1'b1);
      check("ex_cause", rsp_cause, 64'd1);
      check("ex_tval", rsp_tval, 64'hDEAD0);
      step(2'b00, 0, 0, '0, 0, '0, '0);

      // Spurious response, then reset with requests in flight
      step(2'b00, 0, 1, 56'hE0, 1, 64'd7, 64'd7);
      check("sp_outstanding", outstanding, 0);
      step(2'b01, 0, 0, '0, 0, '0, '0);
      step(2'b01, 0, 0, '0, 0, '0, '0);
      check("ar_pre", outstanding, 2);
      async_reset();
      step(2'b00, 0, 1, 56'hE1, 0, '0, '0);
      step(2'b00, 0, 1, 56'hE2, 0, '0, '0);

      // Watchdog: one request with a silent MMU
      step(2'b01, 0, 0, '0, 0, '0, '0);
      for (int i = 0; i < 10; i++) step(2'b00, 0, 0, '0, 0, '0, '0);
`ifdef ICACHE_AREQ_TRACKER_TIMEOUT_EN
      check("tmo_set", timeout, 1'b1);
`else
      check("tmo_tied", timeout, 1'b0);
`endif
      step(2'b00, 1, 0, '0, 0, '0, '0);
      check("tmo_clr", timeout, 1'b0);
      step(2'b00, 0, 1, 56'hF0, 0, '0, '0);

      // Random traffic against the model
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(127) == 0) begin
            async_reset();
         end else begin
            vaddr = VW'({$urandom(), $urandom(), $urandom()});
            step(NR_CH'($urandom()), $urandom_range(15) == 0, $urandom_range(2) == 0,
                 PLEN'({$urandom(), $urandom()}), 1'($urandom()),
                 XLEN'({$urandom(), $urandom()}), XLEN'({$urandom(), $urandom()}));
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/icache_areq_tracker.md
# icache_areq_tracker

Parametrised multi-channel tracker for I$ address-translation requests. It sits between NR_CH fetch requesters and the single MMU/PMP fetch-translation port, and arbitrates requests round-robin. It keeps up to DEPTH requests outstanding on the in-order MMU port and returns each paddr/exception response to the channel that issued it. Flushed requests are discarded without stalling the MMU.

## Interface
Parameters:
- NR_CH, 2, number of requesting channels (1..8)
- DEPTH, 4, max outstanding MMU requests (power of two, ≥2)
- VLEN, 39, virtual address width
- PLEN, 56, physical address width
- XLEN, 64, exception cause/tval width
- TIMEOUT, 256, watchdog limit in cycles (only used with ICACHE_AREQ_TRACKER_TIMEOUT_EN)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock, reset asynchronous and active-high
- flush_i  in  1  kill all in-flight requests
- ch_req_i  in  NR_CH  per-channel request
- ch_vaddr_i  in  NR_CH*VLEN  per-channel vaddr; channel k uses slice k
- ch_gnt_o  out  NR_CH  one-hot grant, combinational
- ch_rsp_valid_o  out  NR_CH  one-hot response strobe, registered
- ch_rsp_paddr_o  out  PLEN  response paddr, broadcast
- ch_rsp_ex_valid_o  out  1  response carries exception
- ch_rsp_cause_o  out  XLEN  exception cause
- ch_rsp_tval_o  out  XLEN  exception tval
- mmu_fetch_req_o  out  1  issue to MMU
- mmu_fetch_vaddr_o  out  VLEN  issued vaddr
- mmu_fetch_valid_i  in  1  in-order MMU response
- mmu_fetch_paddr_i  in  PLEN  response paddr
- mmu_ex_valid_i, mmu_ex_cause_i, mmu_ex_tval_i  in  1/XLEN/XLEN  response exception
- outstanding_o  out  $clog2(DEPTH+1)  in-flight count
- full_o  out  1  outstanding_o == DEPTH
- timeout_o  out  1  watchdog fired, sticky

## Operation
- **Grant condition.** At most one grant per cycle. A grant requires all of: some ch_req_i set, !full_o, !flush_i, !rst_i.
- **Round-robin arbitration.** The search starts at priority pointer rr_q. Grant channel g, then set rr_q ← (g+1) mod NR_CH. rr_q holds when there is no grant.
- **Issue.** mmu_fetch_req_o = |ch_gnt_o and mmu_fetch_vaddr_o = ch_vaddr_i[g]. The MMU port has no backpressure.
- **ID FIFO.** A grant pushes {g, kill=0} into a DEPTH-entry ID FIFO.
- **Response pop.**
  - mmu_fetch_valid_i pops the FIFO head.
  - If kill=0: the next cycle pulses ch_rsp_valid_o[g] and registers paddr/ex fields.
  - If kill=1: the response is discarded.
- **Flush.** flush_i sets kill=1 on every entry present this cycle, including one popped this same cycle. No push occurs in a flush cycle.
- **Full.** Full blocks grants even if a pop happens in the same cycle.
- **Same-cycle push and pop.** Allowed when not full; the count is unchanged.
- **Spurious response.** mmu_fetch_valid_i with an empty FIFO is ignored and the state is unchanged. This is a verification error.
- **Held data.** Response data outputs hold their last value when the strobe is low. ch_rsp_ex_valid_o is 0 when no strobe.

## Timing
- **Reset values.**
  - Outputs: all registered outputs are 0, outstanding_o=0, full_o=0, timeout_o=0.
  - State: rr_q=0, FIFO empty, all kill bits 0.
  - Combinational outputs: ch_gnt_o and mmu_fetch_req_o are 0 while rst_i is high.
- **Grant latency.** Request to grant: 0 cycles. Channel must hold ch_vaddr_i stable only in the grant cycle.
- **Response latency.** mmu_fetch_valid_i to ch_rsp_valid_o: 1 cycle.
- **Count update.** outstanding_o updates the cycle after push/pop, and full_o is derived from the register.
- **Reset mid-operation.** FIFO, kill bits, watchdog and outputs clear asynchronously. MMU responses after reset is released are spurious and are ignored.
- **Pointer wrap.** FIFO read/write pointers wrap modulo DEPTH. The count is kept in a separate $clog2(DEPTH+1)-bit register.

## Configuration
- **Macro:** ICACHE_AREQ_TRACKER_TIMEOUT_EN.
- **With the macro defined:**
  - A counter increments each cycle while outstanding_o>0 and no pop occurs.
  - The counter clears on pop, on flush_i, or when the FIFO is empty.
  - When the counter reaches TIMEOUT, timeout_o sets and stays set until flush_i or reset.
- **Without the macro:** timeout_o is tied 0 and no counter logic exists.

## Test plan
- **Single channel, in-order.** Reset, then ch_req_i=01 with vaddr 0x1000. Expected:
  - Grant 01 and mmu_fetch_vaddr_o=0x1000 in the same cycle.
  - MMU answers paddr 0x8000_1000 three cycles later; ch_rsp_valid_o=01 one cycle after that, with paddr 0x8000_1000 and ex_valid=0.
- **Round-robin.** Both channels request continuously. Expected:
  - Grants 01,10,01,10.
  - MMU in-order responses return strobes 01,10,01,10.
  - outstanding_o peaks at 4 and full_o=1. No grant while full, even in a pop cycle.
- **Flush mid-flight.** Issue 3 requests, then flush_i in the same cycle as the first response. Expected:
  - All 3 responses are discarded with no ch_rsp_valid_o.
  - No grant in the flush cycle; a request on the next cycle is granted normally, and its response is delivered.
- **Exception forwarding.** MMU response has ex_valid=1, cause=1, tval=0xDEAD0. Expected: the strobe on the owning channel carries ch_rsp_ex_valid_o=1, cause 1 and tval 0xDEAD0.
- **Spurious response and async reset.** Expected:
  - mmu_fetch_valid_i with an empty FIFO produces no strobe and no count change.
  - Asserting rst_i with 2 outstanding clears outstanding_o to 0 immediately, and later responses are ignored.
- **Timeout (macro defined, TIMEOUT=8).** One request, MMU silent. Expected: timeout_o=1 after 8 cycles; it stays high until flush_i, then reads 0.
